// File: rtl/stamp_pkg.sv
// Shared types and constants for the stamp dispatcher.
// The optional take write-back path is enabled by the DISPATCH_TAKE_EN macro.
package stamp_pkg;

  localparam int SLOTS  = 8;
  localparam int CMD_W  = 88;
  localparam int SLOT_W = 3;
  localparam int UNITS  = 3;

  localparam int STAMP_EX  = 2;
  localparam int STAMP_MEM = 1;
  localparam int STAMP_WB  = 0;

  localparam int STAMP_LSB = 0;
  localparam int STAMP_MSB = 2;
  localparam int STAMP_W   = STAMP_MSB - STAMP_LSB + 1;
  localparam int TAKE_LSB  = 30;
  localparam int TAKE_MSB  = 34;
  localparam int TAKE_W    = TAKE_MSB - TAKE_LSB + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_STAMP = 2'd3
  } unit_state_t;

  typedef struct packed {
    logic              found;
    logic [SLOT_W-1:0] slot;
  } pick_t;

  // Highest set index wins: slot 7 is the oldest entry on the conveyor.
  function automatic pick_t oldest_pick(input logic [SLOTS-1:0] elig);
    pick_t p;
    p = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (elig[i]) begin
        p.found = 1'b1;
        p.slot  = SLOT_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/stamp_dispatcher_unit.sv
// One stage unit: issue FSM, slot tracker and stamp/take write-back generation.
// DISPATCH_TAKE_EN adds the captured take value for the exec unit.
//
// state   | meaning
// S_IDLE  | no entry; accepts a pick from the top-level encoder
// S_ISSUE | valid asserted, waiting for unit ready
// S_BUSY  | entry accepted, waiting for done pulse
// S_STAMP | writing stamp; held while the entry sits in slot 0 during a stall
module dispatch_unit
  import stamp_pkg::*;
#(
  parameter int STAGE = STAMP_EX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      advance,
  input  logic                      pick_valid,
  input  logic [SLOT_W-1:0]         pick_slot,
  input  logic [CMD_W-1:0]          pick_cmd,
  input  logic                      ready,
  input  logic                      done,
`ifdef DISPATCH_TAKE_EN
  input  logic [TAKE_W-1:0]         take,
  output logic [SLOTS-1:0]          take_en,
  output logic [SLOTS*TAKE_W-1:0]   take_vals,
`endif
  output logic                      busy,
  output logic [SLOT_W-1:0]         slot,
  output logic                      valid,
  output logic [CMD_W-1:0]          cmd,
  output logic [SLOTS-1:0]          stamp_en,
  output logic [SLOTS*STAMP_W-1:0]  stamp_vals,
  output logic                      err
);

  localparam logic [STAMP_W-1:0] STAGE_BIT = STAMP_W'(1 << STAGE);

  unit_state_t          state, state_nxt;
  logic [STAMP_W-1:0]   stamp_q;
  logic                 overflow;
  logic                 can_stamp;
  logic [SLOT_W-1:0]    tgt;
  logic [SLOT_W-1:0]    idx;

  assign overflow  = advance && (state != S_IDLE) && (slot == SLOT_W'(SLOTS - 1));
  assign can_stamp = (state == S_STAMP) && !overflow && (advance || slot != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      slot    <= '0;
      cmd     <= '0;
      stamp_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_valid) begin
        slot    <= pick_slot + SLOT_W'(advance);
        cmd     <= pick_cmd;
        stamp_q <= pick_cmd[STAMP_MSB:STAMP_LSB];
      end else if (state != S_IDLE && advance) begin
        slot <= slot + SLOT_W'(1);
      end
    end
  end

`ifdef DISPATCH_TAKE_EN
  logic [TAKE_W-1:0] take_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      take_q <= '0;
    else if (state == S_BUSY && done)
      take_q <= take;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_valid) state_nxt = S_ISSUE;
      S_ISSUE: if (ready)      state_nxt = S_BUSY;
      S_BUSY:  if (done)       state_nxt = S_STAMP;
      S_STAMP: if (advance || slot != '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // An entry pushed off the end of the conveyor is lost; drop it.
    if (overflow)
      state_nxt = S_IDLE;
  end

  always_comb begin
    busy       = (state != S_IDLE);
    valid      = (state == S_ISSUE);
    err        = overflow;
    stamp_en   = '0;
    stamp_vals = '0;
    tgt        = slot + SLOT_W'(advance);
    idx        = tgt - SLOT_W'(1);
`ifdef DISPATCH_TAKE_EN
    take_en    = '0;
    take_vals  = '0;
`endif
    if (can_stamp) begin
      stamp_en[idx] = 1'b1;
      stamp_vals[int'(idx)*STAMP_W +: STAMP_W] = stamp_q | STAGE_BIT;
`ifdef DISPATCH_TAKE_EN
      if (STAGE == STAMP_EX) begin
        take_en[idx] = 1'b1;
        take_vals[int'(idx)*TAKE_W +: TAKE_W] = take_q;
      end
`endif
    end
  end

endmodule

// File: rtl/stamp_dispatcher.sv
// Oldest-first issue scheduler for the 8-slot conveyor with three stage units.
// DISPATCH_TAKE_EN enables the exec take write-back; otherwise take outputs are 0.
module stamp_dispatcher
  import stamp_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     conveyor_stop,
  input  logic [SLOTS*3-1:0]       reg_start_flat,
  input  logic [SLOTS*CMD_W-1:0]   reg_out_flat,
  output logic                     ex_valid,
  output logic                     mem_valid,
  output logic                     wb_valid,
  input  logic                     ex_ready,
  input  logic                     mem_ready,
  input  logic                     wb_ready,
  output logic [CMD_W-1:0]         ex_cmd,
  output logic [CMD_W-1:0]         mem_cmd,
  output logic [CMD_W-1:0]         wb_cmd,
  input  logic                     ex_done,
  input  logic                     mem_done,
  input  logic                     wb_done,
  input  logic [TAKE_W-1:0]        ex_take,
  output logic [SLOTS-1:0]         stamp_in,
  output logic [SLOTS*STAMP_W-1:0] stamp_flat,
  output logic [SLOTS-1:0]         take_in,
  output logic [SLOTS*TAKE_W-1:0]  take_flat,
  output logic                     sched_err
);

  logic                       advance;
  logic [SLOTS-1:0]           pick_ok;
  logic [SLOTS-1:0]           owned;
  logic [SLOTS-1:0]           claimed;
  logic [SLOTS-1:0]           elig;
  pick_t                      pick      [UNITS];
  logic [UNITS-1:0]           grant;
  logic [CMD_W-1:0]           pick_cmd  [UNITS];
  logic [UNITS-1:0]           unit_ready, unit_done;
  logic [UNITS-1:0]           unit_busy, unit_valid, unit_err;
  logic [SLOT_W-1:0]          unit_slot [UNITS];
  logic [CMD_W-1:0]           unit_cmd  [UNITS];
  logic [SLOTS-1:0]           u_stamp_en   [UNITS];
  logic [SLOTS*STAMP_W-1:0]   u_stamp_vals [UNITS];

  assign advance    = !conveyor_stop;
  assign unit_ready = {wb_ready, mem_ready, ex_ready};
  assign unit_done  = {wb_done, mem_done, ex_done};

  // Slot 7 would leave the conveyor on this edge, so it is not granted.
  assign pick_ok = advance ? {1'b0, {(SLOTS-1){1'b1}}} : '1;

  always_comb begin
    owned = '0;
    for (int u = 0; u < UNITS; u++)
      if (unit_busy[u]) owned[unit_slot[u]] = 1'b1;
  end

  // Units pick in ex, mem, wb order; each same-cycle grant is hidden from later units.
  always_comb begin
    claimed = owned;
    elig    = '0;
    grant   = '0;
    for (int u = 0; u < UNITS; u++) begin
      for (int s = 0; s < SLOTS; s++)
        elig[s] = reg_start_flat[s*3 + (STAMP_EX - u)];
      elig        = elig & ~claimed & pick_ok;
      pick[u]     = oldest_pick(elig);
      pick_cmd[u] = reg_out_flat[int'(pick[u].slot)*CMD_W +: CMD_W];
      grant[u]    = pick[u].found && !unit_busy[u];
      if (grant[u]) claimed[pick[u].slot] = 1'b1;
    end
  end

`ifdef DISPATCH_TAKE_EN
  logic [SLOTS-1:0]        u_take_en   [UNITS];
  logic [SLOTS*TAKE_W-1:0] u_take_vals [UNITS];
`endif

  for (genvar u = 0; u < UNITS; u++) begin : g_unit
    dispatch_unit #(.STAGE(STAMP_EX - u)) u_unit (
      .clk        (clk),
      .reset      (reset),
      .advance    (advance),
      .pick_valid (grant[u]),
      .pick_slot  (pick[u].slot),
      .pick_cmd   (pick_cmd[u]),
      .ready      (unit_ready[u]),
      .done       (unit_done[u]),
`ifdef DISPATCH_TAKE_EN
      .take       ((u == 0) ? ex_take : '0),
      .take_en    (u_take_en[u]),
      .take_vals  (u_take_vals[u]),
`endif
      .busy       (unit_busy[u]),
      .slot       (unit_slot[u]),
      .valid      (unit_valid[u]),
      .cmd        (unit_cmd[u]),
      .stamp_en   (u_stamp_en[u]),
      .stamp_vals (u_stamp_vals[u]),
      .err        (unit_err[u])
    );
  end

  assign ex_valid  = unit_valid[0];
  assign mem_valid = unit_valid[1];
  assign wb_valid  = unit_valid[2];
  assign ex_cmd    = unit_cmd[0];
  assign mem_cmd   = unit_cmd[1];
  assign wb_cmd    = unit_cmd[2];

  always_comb begin
    stamp_in   = '0;
    stamp_flat = '0;
    for (int u = 0; u < UNITS; u++) begin
      stamp_in   |= u_stamp_en[u];
      stamp_flat |= u_stamp_vals[u];
    end
  end

`ifdef DISPATCH_TAKE_EN
  always_comb begin
    take_in   = '0;
    take_flat = '0;
    for (int u = 0; u < UNITS; u++) begin
      take_in   |= u_take_en[u];
      take_flat |= u_take_vals[u];
    end
  end
`else
  logic unused_ex_take;
  assign unused_ex_take = ^ex_take;
  assign take_in        = '0;
  assign take_flat      = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sched_err <= 1'b0;
    else if (|unit_err)
      sched_err <= 1'b1;
  end

endmodule

// File: tb/tb_stamp_dispatcher.sv
// Scoreboard bench for stamp_dispatcher: issue commands and stamp writes are
// queued when stimulus is driven and popped as the DUT produces them.
module tb_stamp_dispatcher;
  import stamp_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         conveyor_stop = 1'b1;
  logic [23:0]  reg_start_flat = '0;
  logic [703:0] reg_out_flat = '0;
  logic         ex_valid, mem_valid, wb_valid;
  logic         ex_ready = 1'b0, mem_ready = 1'b0, wb_ready = 1'b0;
  logic [87:0]  ex_cmd, mem_cmd, wb_cmd;
  logic         ex_done = 1'b0, mem_done = 1'b0, wb_done = 1'b0;
  logic [4:0]   ex_take = '0;
  logic [7:0]   stamp_in, take_in;
  logic [23:0]  stamp_flat;
  logic [39:0]  take_flat;
  logic         sched_err;

  always #5 clk = ~clk;

  stamp_dispatcher dut (
    .clk(clk), .reset(reset), .conveyor_stop(conveyor_stop),
    .reg_start_flat(reg_start_flat), .reg_out_flat(reg_out_flat),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_ready(ex_ready), .mem_ready(mem_ready), .wb_ready(wb_ready),
    .ex_cmd(ex_cmd), .mem_cmd(mem_cmd), .wb_cmd(wb_cmd),
    .ex_done(ex_done), .mem_done(mem_done), .wb_done(wb_done),
    .ex_take(ex_take), .stamp_in(stamp_in), .stamp_flat(stamp_flat),
    .take_in(take_in), .take_flat(take_flat), .sched_err(sched_err)
  );

  typedef struct packed {
    logic [7:0]  en;
    logic [23:0] val;
    logic [7:0]  ten;
    logic [39:0] tval;
  } stamp_rec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [87:0] ex_q[$], mem_q[$], wb_q[$];
  stamp_rec_t  st_q[$];
  stamp_rec_t  rec;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] slot_stamp(input int s);
    case (s)
      0, 1:    return 3'b100;
      5:       return 3'b110;
      6:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [87:0] mk_cmd(input int s);
    return {64'hC0DE_0000_0000_0000 | (64'(s) * 64'h1_0001), 21'(s * 7 + 3), slot_stamp(s)};
  endfunction

  // Adds one stamp write (conveyor slot tslot, i.e. enable bit tslot-1) to a record.
  function automatic stamp_rec_t rec_add(input stamp_rec_t r, input int tslot,
                                         input logic [2:0] v, input logic [4:0] tk,
                                         input bit is_ex);
    stamp_rec_t o;
    o = r;
    o.en[tslot-1] = 1'b1;
    o.val[(tslot-1)*3 +: 3] = v;
`ifdef DISPATCH_TAKE_EN
    if (is_ex) begin
      o.ten[tslot-1] = 1'b1;
      o.tval[(tslot-1)*5 +: 5] = tk;
    end
`else
    if (is_ex) o.tval = o.tval | 40'(tk & 5'd0);
`endif
    return o;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_ex_q"},    ex_q.size(),  0);
    chk({tag, "_mem_q"},   mem_q.size(), 0);
    chk({tag, "_wb_q"},    wb_q.size(),  0);
    chk({tag, "_stamp_q"}, st_q.size(),  0);
  endtask

  task automatic issue_mon(input int u, input logic v, input logic r, input logic [87:0] c);
    logic [87:0] e;
    if (v && r) begin
      case (u)
        0: if (ex_q.size()  == 0) begin chk("ex_unexpected_issue",  v, 0); return; end else e = ex_q.pop_front();
        1: if (mem_q.size() == 0) begin chk("mem_unexpected_issue", v, 0); return; end else e = mem_q.pop_front();
        default: if (wb_q.size() == 0) begin chk("wb_unexpected_issue", v, 0); return; end else e = wb_q.pop_front();
      endcase
      chk(u == 0 ? "ex_cmd" : (u == 1 ? "mem_cmd" : "wb_cmd"), c, e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      issue_mon(0, ex_valid,  ex_ready,  ex_cmd);
      issue_mon(1, mem_valid, mem_ready, mem_cmd);
      issue_mon(2, wb_valid,  wb_ready,  wb_cmd);
      if (stamp_in != '0 || take_in != '0) begin
        if (st_q.size() == 0) begin
          chk("stamp_unexpected", {take_in, stamp_in}, 0);
        end else begin
          rec = st_q.pop_front();
          chk("stamp_in",   stamp_in,   rec.en);
          chk("stamp_flat", stamp_flat, rec.val);
          chk("take_in",    take_in,    rec.ten);
          chk("take_flat",  take_flat,  rec.tval);
        end
      end
    end
  end

  initial begin
    for (int s = 0; s < SLOTS; s++) reg_out_flat[s*88 +: 88] = mk_cmd(s);

    // Reset holds everything at zero even with every slot ready.
    reg_start_flat = '1;
    step(2);
    @(negedge clk);
    chk("rst_ex_valid",   ex_valid,   0);
    chk("rst_mem_valid",  mem_valid,  0);
    chk("rst_wb_valid",   wb_valid,   0);
    chk("rst_stamp_in",   stamp_in,   0);
    chk("rst_stamp_flat", stamp_flat, 0);
    chk("rst_take",       {take_in, take_flat}, 0);
    chk("rst_cmds",       {ex_cmd, mem_cmd, wb_cmd}, 0);
    chk("rst_sched_err",  sched_err,  0);
    reg_start_flat = '0;
    step(1);
    reset = 1'b0;
    step(1);

    // Slots 3 and 6 exec-ready, stalled: slot 6 is issued, stamp lands on slot 6.
    reg_start_flat[3*3+2] = 1'b1;
    reg_start_flat[6*3+2] = 1'b1;
    ex_q.push_back(mk_cmd(6));
    step(1);
    reg_start_flat = '0;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("t1_ex_valid",  ex_valid,  1);
    chk("t1_mem_valid", mem_valid, 0);
    step(1);
    ex_ready = 1'b0;
    @(negedge clk);
    chk("t1_busy_valid", ex_valid, 0);
    step(1);
    ex_done = 1'b1;
    ex_take = 5'd19;
    st_q.push_back(rec_add('0, 6, 3'b101, 5'd19, 1'b1));
    step(1);
    ex_done = 1'b0;
    settle();
    drained("t1");
    step(1);

    // Mem entry in slot 0 during a stall: stamp waits for the conveyor to move.
    reg_start_flat[0*3+1] = 1'b1;
    mem_q.push_back(mk_cmd(0));
    step(1);
    reg_start_flat = '0;
    mem_ready = 1'b1;
    step(1);
    mem_ready = 1'b0;
    mem_done = 1'b1;
    step(1);
    mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_hold", stamp_in, 0);
    end
    step(1);
    conveyor_stop = 1'b0;
    st_q.push_back(rec_add('0, 1, 3'b110, 5'd0, 1'b0));
    settle();
    drained("t2");
    step(1);
    conveyor_stop = 1'b1;
    step(1);

    // Exec on slot 2 and wb on slot 5 complete together.
    reg_start_flat[2*3+2] = 1'b1;
    reg_start_flat[5*3+0] = 1'b1;
    ex_q.push_back(mk_cmd(2));
    wb_q.push_back(mk_cmd(5));
    step(1);
    reg_start_flat = '0;
    ex_ready = 1'b1;
    wb_ready = 1'b1;
    step(1);
    ex_ready = 1'b0;
    wb_ready = 1'b0;
    ex_done = 1'b1;
    wb_done = 1'b1;
    ex_take = 5'd7;
    st_q.push_back(rec_add(rec_add('0, 2, 3'b100, 5'd7, 1'b1), 5, 3'b111, 5'd0, 1'b0));
    step(1);
    ex_done = 1'b0;
    wb_done = 1'b0;
    settle();
    drained("t3");
    step(1);

    // Slot 4 ready for ex and mem: ex owns it, mem takes slot 1 and never slot 4.
    reg_start_flat[4*3+2] = 1'b1;
    reg_start_flat[4*3+1] = 1'b1;
    reg_start_flat[1*3+1] = 1'b1;
    ex_q.push_back(mk_cmd(4));
    mem_q.push_back(mk_cmd(1));
    step(1);
    reg_start_flat[1*3+1] = 1'b0;
    mem_ready = 1'b1;
    step(1);
    mem_ready = 1'b0;
    mem_done = 1'b1;
    st_q.push_back(rec_add('0, 1, 3'b110, 5'd0, 1'b0));
    step(1);
    mem_done = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_mem_valid", mem_valid, 0);
      chk("t4_ex_valid",  ex_valid,  1);
    end
    // Reset mid-operation aborts the outstanding ex entry without a stamp.
    step(1);
    reset = 1'b1;
    reg_start_flat = '0;
    ex_q.delete();
    @(negedge clk);
    chk("t4_rst_ex_valid", ex_valid, 0);
    step(1);
    reset = 1'b0;
    step(3);
    settle();
    drained("t4");
    step(1);

    // Pick while advancing: tracked slot moves 6 -> 7, stamp targets slot 7.
    reg_start_flat[6*3+2] = 1'b1;
    conveyor_stop = 1'b0;
    ex_q.push_back(mk_cmd(6));
    step(1);
    conveyor_stop = 1'b1;
    reg_start_flat = '0;
    ex_ready = 1'b1;
    step(1);
    ex_ready = 1'b0;
    ex_done = 1'b1;
    ex_take = 5'd19;
    st_q.push_back(rec_add('0, 7, 3'b101, 5'd19, 1'b1));
    step(1);
    ex_done = 1'b0;
    settle();
    drained("t5");
    step(1);

    // Advancing an entry out of slot 7 raises the sticky error.
    reg_start_flat[6*3+2] = 1'b1;
    conveyor_stop = 1'b0;
    step(1);
    reg_start_flat = '0;
    @(negedge clk);
    chk("t6_err_before", sched_err, 0);
    chk("t6_ex_valid",   ex_valid,  1);
    step(1);
    conveyor_stop = 1'b1;
    @(negedge clk);
    chk("t6_err_set",     sched_err, 1);
    chk("t6_ex_dropped",  ex_valid,  0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      @(negedge clk);
      chk("t6_err_sticky", sched_err, 1);
    end
    step(1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_err_cleared", sched_err, 0);
    step(1);
    reset = 1'b0;
    step(2);
    settle();
    drained("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
